fb_mem_responder: RTL and testbench

FB_MEM_RESPONDER -- requirements
Module: fb_mem_responder

---
 rtl/fb_mem_responder_pkg.sv | 23 ++
 rtl/fb_mem_responder_if.sv | 27 ++
 rtl/fb_mem_sram.sv | 37 +++
 rtl/fb_mem_responder.sv | 119 +++++++++++
 tb/tb_fb_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_mem_responder_pkg.sv
// Shared frame-buffer types: op and FSM encodings, read latency, default geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fb_mem_responder_pkg;

    // Default frame-buffer geometry: 16K words of 32 bits.
    localparam int FB_MEM_DEPTH = 16384;
    localparam int FB_ADDR_W    = 14;

    // Cycles from read transfer to the broadcast strobe.
    localparam int RD_LATENCY   = 2;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } fb_op_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } fb_state_e;

endpackage

// File: rtl/fb_mem_responder_if.sv
// Arbiter <-> frame-buffer request and broadcast-return bundle.
// Latency: n/a (wires only).
// Backpressure: arb_in_rts/arb_out_rtr handshake; the return strobe cannot be stalled.
interface fb_mem_responder_if;

    logic        arb_in_rts;
    logic        arb_out_rtr;
    logic        arb_in_op;
    logic [3:0]  arb_in_wben;
    logic [15:0] arb_in_addr;
    logic [31:0] arb_in_data;
    logic [31:0] arb_bcast_out_data;
    logic        arb_bcast_out_xfc;

    // Arbiter side: issues requests, observes returns.
    modport master (
        output arb_in_rts, arb_in_op, arb_in_wben, arb_in_addr, arb_in_data,
        input  arb_out_rtr, arb_bcast_out_data, arb_bcast_out_xfc
    );

    // Memory side: accepts requests, broadcasts read data.
    modport slave (
        input  arb_in_rts, arb_in_op, arb_in_wben, arb_in_addr, arb_in_data,
        output arb_out_rtr, arb_bcast_out_data, arb_bcast_out_xfc
    );

endinterface

// File: rtl/fb_mem_sram.sv
// Single-port frame-buffer array: byte-enabled synchronous write, registered read.
// Latency: write visible next cycle; read data on o_rdat one cycle after i_en.
// Backpressure: none; one access per cycle, read data holds until the next read.
module fb_mem_sram #(
    parameter int MEM_DEPTH = 16384,
    parameter int ADDR_W    = 14
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [3:0]        i_wben,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdat,
    output logic [31:0]       o_rdat
);

    logic [31:0] r_mem [MEM_DEPTH];
    logic [31:0] r_rdat;

    // One access per cycle: lane-masked write, or read into the output register.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_wben[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_wdat[8*b +: 8];
                    end
                end
            end else begin
                r_rdat <= r_mem[i_addr];
            end
        end
    end

    assign o_rdat = r_rdat;

endmodule

// File: rtl/fb_mem_responder.sv
// Frame-buffer responder: request handshake, clear sweep FSM, read-return broadcast.
// Latency: writes land one cycle after transfer; read strobe exactly 2 cycles after transfer.
// Backpressure: rtr low throughout the clear sweep; returns are broadcast without stall.
module fb_mem_responder
    import fb_mem_responder_pkg::*;
#(
    parameter int MEM_DEPTH = FB_MEM_DEPTH,
    parameter int ADDR_W    = FB_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 clear_strobe,
    output logic                 mem_is_idle,
    fb_mem_responder_if.slave    arb
);

    localparam logic [16:0]       LP_DEPTH = 17'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(MEM_DEPTH - 1);

    fb_state_e              r_state;
    logic                   r_rtr;
    logic [ADDR_W-1:0]      r_clr_cnt;
    logic [RD_LATENCY-1:0]  r_rd_vld;
    logic                   r_rd_oor;
    logic [31:0]            r_out_dat;

    logic                   w_fire;
    logic                   w_rd_fire;
    logic                   w_wr_fire;
    logic                   w_oor;
    logic                   w_clearing;
    logic                   w_sram_en;
    logic                   w_sram_we;
    logic [3:0]             w_sram_wben;
    logic [ADDR_W-1:0]      w_sram_addr;
    logic [31:0]            w_sram_wdat;
    logic [31:0]            w_sram_rdat;

    // Requests touch the array on their transfer edge, so a write is visible to a
    // read transferred the very next cycle and nothing collides with the sweep:
    // rtr is low for every cycle the sweep owns the port.
    assign w_fire      = arb.arb_in_rts & r_rtr;
    assign w_oor       = {1'b0, arb.arb_in_addr} >= LP_DEPTH;
    assign w_rd_fire   = w_fire & (arb.arb_in_op == OP_READ);
    assign w_wr_fire   = w_fire & (arb.arb_in_op == OP_WRITE);
    assign w_clearing  = (r_state == ST_CLEAR);

    // Out-of-range requests never reach the array: writes drop, reads return zero.
    assign w_sram_en   = w_clearing | (w_fire & ~w_oor);
    assign w_sram_we   = w_clearing | w_wr_fire;
    assign w_sram_wben = w_clearing ? 4'hF : arb.arb_in_wben;
    assign w_sram_addr = w_clearing ? r_clr_cnt : arb.arb_in_addr[ADDR_W-1:0];
    assign w_sram_wdat = w_clearing ? 32'h0 : arb.arb_in_data;

    fb_mem_sram #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_sram (
        .clk    (clk),
        .i_en   (w_sram_en),
        .i_we   (w_sram_we),
        .i_wben (w_sram_wben),
        .i_addr (w_sram_addr),
        .i_wdat (w_sram_wdat),
        .o_rdat (w_sram_rdat)
    );

    // Clear/ready FSM: sweep one word per cycle; a strobe (re)starts the sweep at 0.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state   <= ST_CLEAR;
            r_rtr     <= 1'b0;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (clear_strobe) begin
                        r_clr_cnt <= '0;
                    end else if (r_clr_cnt == LP_LAST) begin
                        r_state   <= ST_READY;
                        r_rtr     <= 1'b1;
                        r_clr_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                    end
                end
                ST_READY: begin
                    if (clear_strobe) begin
                        r_state   <= ST_CLEAR;
                        r_rtr     <= 1'b0;
                        r_clr_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // Return pipeline: array data is captured one cycle after transfer and held
    // on the broadcast bus; data already captured is unaffected by a later sweep.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_rd_vld  <= '0;
            r_rd_oor  <= 1'b0;
            r_out_dat <= 32'h0;
        end else begin
            r_rd_vld <= {r_rd_vld[RD_LATENCY-2:0], w_rd_fire};
            r_rd_oor <= w_oor;
            if (r_rd_vld[RD_LATENCY-2]) begin
                r_out_dat <= r_rd_oor ? 32'h0 : w_sram_rdat;
            end
        end
    end

    assign arb.arb_out_rtr        = r_rtr;
    assign arb.arb_bcast_out_xfc  = r_rd_vld[RD_LATENCY-1];
    assign arb.arb_bcast_out_data = r_out_dat;
    assign mem_is_idle            = r_rtr & ~(|r_rd_vld);

endmodule

// File: tb/tb_fb_mem_responder.sv
// Randomized scoreboard bench for fb_mem_responder against a word-array reference model.
// Latency: expects each read strobe exactly 2 cycles after its transfer.
// Backpressure: driver holds a request until rtr is seen high, bounded by a timeout.
module tb_fb_mem_responder;
    import fb_mem_responder_pkg::*;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int TMO   = 8 * DEPTH;

    typedef struct {
        logic [31:0] dat;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_;
    logic clear_strobe;
    logic mem_is_idle;

    fb_mem_responder_if ifc();

    fb_mem_responder #(
        .MEM_DEPTH (DEPTH),
        .ADDR_W    (AW)
    ) dut (
        .clk          (clk),
        .rst_         (rst_),
        .clear_strobe (clear_strobe),
        .mem_is_idle  (mem_is_idle),
        .arb          (ifc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    bit          dead   = 1'b0;
    exp_t        exp_q[$];
    logic [31:0] ref_mem [DEPTH];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    endtask

    // Reference: memory is a plain word array; a read returns whatever the array
    // holds at transfer time, or zero beyond the end of memory.
    task automatic model_req(input logic op, input logic [15:0] a,
                             input logic [3:0] be, input logic [31:0] d);
        exp_t e;
        logic [AW-1:0] idx;
        idx = a[AW-1:0];
        if (op == OP_WRITE) begin
            if (32'(a) < DEPTH) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
            end
        end else begin
            e.dat = (32'(a) < DEPTH) ? ref_mem[idx] : 32'h0;
            e.due = cyc + 2;
            exp_q.push_back(e);
        end
    endtask

    // Present a request at a negedge; it transfers on the next posedge once rtr is high.
    task automatic do_req(input logic op, input logic [15:0] a, input logic [3:0] be,
                          input logic [31:0] d, input logic strobe);
        int w;
        if (dead) return;
        w = 0;
        @(negedge clk);
        ifc.arb_in_rts  = 1'b1;
        ifc.arb_in_op   = op;
        ifc.arb_in_addr = a;
        ifc.arb_in_wben = be;
        ifc.arb_in_data = d;
        clear_strobe    = strobe;
        while (!ifc.arb_out_rtr && w < TMO) begin
            @(negedge clk);
            w++;
        end
        if (!ifc.arb_out_rtr) begin
            checks++;
            errors++;
            dead = 1'b1;
            ifc.arb_in_rts = 1'b0;
            $display("FAIL rtr_timeout: rtr still %b after %0d cycles, expected 1", ifc.arb_out_rtr, w);
            return;
        end
        model_req(op, a, be, d);
        if (strobe) zero_model();
    endtask

    task automatic idle_cyc();
        @(negedge clk);
        ifc.arb_in_rts = 1'b0;
        clear_strobe   = 1'b0;
    endtask

    // Count cycles with rtr low until the sweep completes.
    task automatic wait_clear(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        ifc.arb_in_rts = 1'b0;
        clear_strobe   = 1'b0;
        while (!ifc.arb_out_rtr && n < TMO) begin
            n++;
            @(negedge clk);
        end
        check(nm, n, DEPTH);
        zero_model();
    endtask

    // Monitor: every strobe must match the oldest expectation in data and cycle;
    // between strobes the data bus must hold the last returned word.
    initial begin : monitor
        exp_t        e;
        logic [31:0] hold_exp;
        hold_exp = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_) begin
                hold_exp = 32'h0;
            end else if (ifc.arb_bcast_out_xfc) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfc: strobe with data %h at cycle %0d, expected no strobe",
                             ifc.arb_bcast_out_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", ifc.arb_bcast_out_data, e.dat);
                    check("rd_latency", cyc, e.due);
                    hold_exp = e.dat;
                end
            end else begin
                check("data_hold", ifc.arb_bcast_out_data, hold_exp);
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation exceeded 60000 cycles, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic        op;
        logic [15:0] a;
        logic [3:0]  be;
        logic [31:0] d;
        int          n;

        rst_            = 1'b0;
        clear_strobe    = 1'b0;
        ifc.arb_in_rts  = 1'b0;
        ifc.arb_in_op   = 1'b0;
        ifc.arb_in_wben = 4'h0;
        ifc.arb_in_addr = 16'h0;
        ifc.arb_in_data = 32'h0;
        zero_model();

        repeat (3) @(negedge clk);
        check("rst_rtr",  32'(ifc.arb_out_rtr), 32'd0);
        check("rst_xfc",  32'(ifc.arb_bcast_out_xfc), 32'd0);
        check("rst_data", ifc.arb_bcast_out_data, 32'h0);
        check("rst_idle", 32'(mem_is_idle), 32'd0);

        @(posedge clk);
        #1 rst_ = 1'b1;
        wait_clear("clear_len_after_reset");
        check("idle_when_ready", 32'(mem_is_idle), 32'd1);

        // Freshly swept memory reads back as zero.
        for (int i = 0; i < 4; i++)
            do_req(OP_READ, 16'($urandom_range(0, DEPTH - 1)), 4'h0, 32'h0, 1'b0);

        // Byte-lane merge: expected 0xAA22CCDD.
        do_req(OP_WRITE, 16'd5, 4'hF, 32'hAABBCCDD, 1'b0);
        do_req(OP_WRITE, 16'd5, 4'h4, 32'h11223344, 1'b0);
        do_req(OP_READ,  16'd5, 4'h0, 32'h0, 1'b0);
        idle_cyc();
        check("idle_read_stage1", 32'(mem_is_idle), 32'd0);
        idle_cyc();
        check("idle_read_strobe", 32'(mem_is_idle), 32'd0);
        idle_cyc();
        check("idle_read_done", 32'(mem_is_idle), 32'd1);

        // Read directly after write, and a no-lane write.
        do_req(OP_WRITE, 16'd7, 4'hF, $urandom(), 1'b0);
        do_req(OP_READ,  16'd7, 4'h0, 32'h0, 1'b0);
        do_req(OP_WRITE, 16'd7, 4'h0, $urandom(), 1'b0);
        do_req(OP_READ,  16'd7, 4'h0, 32'h0, 1'b0);

        // Back-to-back reads.
        for (int i = 0; i < 3; i++) do_req(OP_WRITE, 16'(i), 4'hF, $urandom(), 1'b0);
        for (int i = 0; i < 3; i++) do_req(OP_READ,  16'(i), 4'h0, 32'h0, 1'b0);

        // Out of range: zero return, aliased in-range word untouched.
        do_req(OP_WRITE, 16'd3, 4'hF, 32'h0BADF00D, 1'b0);
        do_req(OP_READ,  16'(DEPTH + 3), 4'h0, 32'h0, 1'b0);
        do_req(OP_WRITE, 16'(DEPTH + 3), 4'hF, 32'hDEADBEEF, 1'b0);
        do_req(OP_READ,  16'd3, 4'h0, 32'h0, 1'b0);
        do_req(OP_READ,  16'(DEPTH + 3), 4'h0, 32'h0, 1'b0);
        do_req(OP_READ,  16'hFFFF, 4'h0, 32'h0, 1'b0);
        idle_cyc();

        // Random mix, biased to a few addresses to provoke read-after-write.
        repeat (400) begin
            if ($urandom_range(0, 4) == 0) begin
                idle_cyc();
            end else begin
                op = 1'($urandom_range(0, 1));
                a  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, DEPTH + 7))
                                                 : 16'($urandom_range(0, 7));
                be = 4'($urandom_range(0, 15));
                d  = $urandom();
                do_req(op, a, be, d, 1'b0);
            end
        end

        // Clear strobe together with a read: pre-clear data returned, then full sweep.
        do_req(OP_WRITE, 16'd5, 4'hF, 32'hCAFE1234, 1'b0);
        do_req(OP_READ,  16'd5, 4'h0, 32'h0, 1'b1);
        wait_clear("clear_len_after_strobe");
        check("idle_after_strobe_clear", 32'(mem_is_idle), 32'd1);
        for (int i = 0; i < DEPTH; i++) do_req(OP_READ, 16'(i), 4'h0, 32'h0, 1'b0);

        // Reset with reads in flight, then again mid-sweep.
        do_req(OP_WRITE, 16'd9, 4'hF, 32'h5A5AA5A5, 1'b0);
        do_req(OP_READ,  16'd9, 4'h0, 32'h0, 1'b0);
        do_req(OP_READ,  16'd9, 4'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst_           = 1'b0;
        ifc.arb_in_rts = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rstmid_rtr",  32'(ifc.arb_out_rtr), 32'd0);
        check("rstmid_xfc",  32'(ifc.arb_bcast_out_xfc), 32'd0);
        check("rstmid_data", ifc.arb_bcast_out_data, 32'h0);
        check("rstmid_idle", 32'(mem_is_idle), 32'd0);
        @(posedge clk);
        #1 rst_ = 1'b1;
        repeat (DEPTH / 2) @(negedge clk);
        @(posedge clk);
        #1 rst_ = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_ = 1'b1;
        wait_clear("clear_len_after_midclear_reset");
        for (int i = 0; i < 8; i++) do_req(OP_READ, 16'(4 + i), 4'h0, 32'h0, 1'b0);

        // Drain outstanding returns.
        idle_cyc();
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            idle_cyc();
            n++;
        end
        idle_cyc();
        check("drain_pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
